// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative restoring divider.
// Holds the FSM state encodings and a width helper used to size the
// iteration counter.
package divider_iter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of bits needed to hold the unsigned value 'value' (at least 1).
    function automatic int bit_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/divider_step.sv
// Single combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module divider_step
    import divider_iter_pkg::*;
#(
    parameter int D_WIDTH = 4
) (
    input  logic [D_WIDTH:0]   rem_i,
    input  logic               quo_msb_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic [D_WIDTH:0]   rem_o,
    output logic               qbit_o
);

    logic [D_WIDTH+1:0] trial;
    logic [D_WIDTH:0]   diff;

    // Trial subtraction; the top trial bit can only be set when the divisor
    // is zero, in which case the low bits already equal the difference.
    always_comb begin
        trial  = {rem_i, quo_msb_i};
        qbit_o = (trial >= {2'b00, d_i});
        diff   = trial[D_WIDTH:0] - {1'b0, d_i};
        rem_o  = qbit_o ? diff : trial[D_WIDTH:0];
    end

endmodule

// File: rtl/divider_iter.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
// Valid/ready on both sides, stall_i freezes all state, async active-low and
// sync active-high resets both return to IDLE.
// Optional macro DIVIDER_DIV0_ERR_EN adds div_zero_o and a fast divide-by-zero path.
module divider_iter
    import divider_iter_pkg::*;
#(
    parameter int N_WIDTH = 8,
    parameter int D_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               reset_an_i,
    input  logic               reset_i,
    input  logic               stall_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [N_WIDTH-1:0] data_n_i,
    input  logic [D_WIDTH-1:0] data_d_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [N_WIDTH-1:0] data_q_o,
    output logic [D_WIDTH-1:0] data_r_o
`ifdef DIVIDER_DIV0_ERR_EN
    ,
    output logic               div_zero_o
`endif
);

    localparam int CNT_W = bit_width(N_WIDTH);

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [N_WIDTH-1:0] quo_q,    quo_d;
    logic [D_WIDTH:0]   rem_q,    rem_d;
    logic [D_WIDTH-1:0] div_q,    div_d;
    logic [N_WIDTH-1:0] q_out_q,  q_out_d;
    logic [D_WIDTH-1:0] r_out_q,  r_out_d;
`ifdef DIVIDER_DIV0_ERR_EN
    logic               dz_q,     dz_d;
`endif

    logic [D_WIDTH:0]   step_rem;
    logic               step_qbit;

    divider_step #(
        .D_WIDTH (D_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[N_WIDTH-1]),
        .d_i       (div_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    assign ready_o  = (state_q == ST_IDLE) & ~stall_i;
    assign valid_o  = (state_q == ST_DONE);
    assign data_q_o = q_out_q;
    assign data_r_o = r_out_q;
`ifdef DIVIDER_DIV0_ERR_EN
    assign div_zero_o = dz_q;
`endif

    // Next-state logic: sync reset wins, stall freezes everything, otherwise run the FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
`ifdef DIVIDER_DIV0_ERR_EN
        dz_d    = dz_q;
`endif
        if (reset_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            quo_d   = '0;
            rem_d   = '0;
            div_d   = '0;
            q_out_d = '0;
            r_out_d = '0;
`ifdef DIVIDER_DIV0_ERR_EN
            dz_d    = 1'b0;
`endif
        end else if (!stall_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        quo_d   = data_n_i;
                        div_d   = data_d_i;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(N_WIDTH - 1);
                        state_d = ST_CALC;
`ifdef DIVIDER_DIV0_ERR_EN
                        if (data_d_i == '0) begin
                            cnt_d   = '0;
                            q_out_d = '1;
                            r_out_d = '0;
                            dz_d    = 1'b1;
                            state_d = ST_DONE;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    rem_d = step_rem;
                    quo_d = {quo_q[N_WIDTH-2:0], step_qbit};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
                        q_out_d = {quo_q[N_WIDTH-2:0], step_qbit};
                        r_out_d = step_rem[D_WIDTH-1:0];
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_d = ST_IDLE;
`ifdef DIVIDER_DIV0_ERR_EN
                        dz_d    = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_an_i) begin
        if (!reset_an_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
`ifdef DIVIDER_DIV0_ERR_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
`ifdef DIVIDER_DIV0_ERR_EN
            dz_q    <= dz_d;
`endif
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Scoreboard testbench for divider_iter (N_WIDTH=8, D_WIDTH=4).
// Build with or without DIVIDER_DIV0_ERR_EN; expectations follow the macro.
module tb_divider_iter;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } result_t;

    logic       clk;
    logic       reset_an_i;
    logic       reset_i;
    logic       stall_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_n_i;
    logic [3:0] data_d_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_q_o;
    logic [3:0] data_r_o;
`ifdef DIVIDER_DIV0_ERR_EN
    logic       div_zero_o;
`endif

    result_t sb[$];
    result_t monExp;
    int      nCompared = 0;
    int      nMismatch = 0;

    divider_iter #(
        .N_WIDTH (8),
        .D_WIDTH (4)
    ) dut (
        .clk_i      (clk),
        .reset_an_i (reset_an_i),
        .reset_i    (reset_i),
        .stall_i    (stall_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_n_i   (data_n_i),
        .data_d_i   (data_d_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_q_o   (data_q_o),
        .data_r_o   (data_r_o)
`ifdef DIVIDER_DIV0_ERR_EN
        ,
        .div_zero_o (div_zero_o)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result for any operand pair, including a zero divisor.
    function automatic result_t model(input logic [7:0] n, input logic [3:0] d);
        result_t res;
        if (d == 4'd0) begin
            res.q  = 8'hFF;
`ifdef DIVIDER_DIV0_ERR_EN
            res.r  = 4'd0;
            res.dz = 1'b1;
`else
            res.r  = n[3:0];
            res.dz = 1'b0;
`endif
        end else begin
            res.q  = n / {4'd0, d};
            res.r  = 4'(n % {4'd0, d});
            res.dz = 1'b0;
        end
        return res;
    endfunction

    // Present one operand pair, push its expected result, return just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] n, input logic [3:0] d,
                                 input logic [7:0] q, input logic [3:0] r, input logic dz);
        result_t exp;
        int      waited;
        exp.q    = q;
        exp.r    = r;
        exp.dz   = dz;
        data_n_i = n;
        data_d_i = d;
        valid_i  = 1'b1;
        waited   = 0;
        while (!ready_o && waited < 50) begin
            tick();
            waited++;
        end
        if (!ready_o) begin
            checkOutput("accept_timeout", 1, 0);
        end
        sb.push_back(exp);
        tick();
        valid_i = 1'b0;
    endtask

    // Count edges until valid_o rises; also report whether ready_o was ever seen high.
    task automatic waitValid(input int budget, output int cycles, output int readySeen);
        cycles    = 0;
        readySeen = 0;
        while (!valid_o && cycles < budget) begin
            if (ready_o) readySeen = 1;
            tick();
            cycles++;
        end
        if (ready_o) readySeen = 1;
    endtask

    // Monitor: compare the head of the scoreboard whenever a result handshake will complete.
    always @(negedge clk) begin
        if (reset_an_i && !reset_i && valid_o && ready_i && !stall_i) begin
            if (sb.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("[TB] FAIL unexpected_result: got q=%0d r=%0d, expected no result", data_q_o, data_r_o);
            end else begin
                monExp = sb.pop_front();
                checkOutput("quotient", int'(data_q_o), int'(monExp.q));
                checkOutput("remainder", int'(data_r_o), int'(monExp.r));
`ifdef DIVIDER_DIV0_ERR_EN
                checkOutput("div_zero", int'(div_zero_o), int'(monExp.dz));
`endif
            end
        end
    end

    logic [7:0] vecN [5] = '{8'd5, 8'd255, 8'd255, 8'd0, 8'd7};
    logic [3:0] vecD [5] = '{4'd9, 4'd15, 4'd1, 4'd5, 4'd7};
    logic [7:0] vecQ [5] = '{8'd0, 8'd17, 8'd255, 8'd0, 8'd1};
    logic [3:0] vecR [5] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0};

    initial begin
        int      cycles;
        int      readySeen;
        result_t rres;
        logic [7:0] rn;
        logic [3:0] rd;

        reset_an_i = 1'b0;
        reset_i    = 1'b0;
        stall_i    = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        data_n_i   = '0;
        data_d_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_an_i = 1'b1;

        $display("[TB] reset state");
        checkOutput("reset_valid_o", int'(valid_o), 0);
        checkOutput("reset_q", int'(data_q_o), 0);
        checkOutput("reset_r", int'(data_r_o), 0);
        checkOutput("reset_ready_o", int'(ready_o), 1);

        $display("[TB] 200/7 latency");
        applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        waitValid(20, cycles, readySeen);
        checkOutput("latency_200_7", cycles, 8);
        checkOutput("ready_low_in_calc", readySeen, 0);
        tick();

        $display("[TB] directed vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecN[i], vecD[i], vecQ[i], vecR[i], 1'b0);
            waitValid(20, cycles, readySeen);
            checkOutput("latency_vec", cycles, 8);
            tick();
        end

        $display("[TB] back-pressure in DONE");
        ready_i = 1'b0;
        applyStimulus(8'd123, 4'd10, 8'd12, 4'd3, 1'b0);
        waitValid(20, cycles, readySeen);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_valid_o", int'(valid_o), 1);
            checkOutput("hold_q", int'(data_q_o), 12);
            checkOutput("hold_r", int'(data_r_o), 3);
        end
        ready_i = 1'b1;
        tick();
        checkOutput("release_ready_o", int'(ready_o), 1);
        checkOutput("release_valid_o", int'(valid_o), 0);

        $display("[TB] stall mid-calculation");
        applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        repeat (3) tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_ready_o", int'(ready_o), 0);
            checkOutput("stall_valid_o", int'(valid_o), 0);
        end
        stall_i = 1'b0;
        waitValid(20, cycles, readySeen);
        checkOutput("latency_stalled", 6 + cycles, 11);
        tick();

        $display("[TB] async reset mid-calculation");
        applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        repeat (3) tick();
        #2;
        reset_an_i = 1'b0;
        #1;
        sb.delete();
        checkOutput("areset_valid_o", int'(valid_o), 0);
        checkOutput("areset_q", int'(data_q_o), 0);
        checkOutput("areset_r", int'(data_r_o), 0);
        checkOutput("areset_ready_o", int'(ready_o), 1);
        tick();
        reset_an_i = 1'b1;
        applyStimulus(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
        waitValid(20, cycles, readySeen);
        checkOutput("latency_100_3", cycles, 8);
        tick();

        $display("[TB] sync reset mid-calculation");
        applyStimulus(8'd50, 4'd6, 8'd8, 4'd2, 1'b0);
        repeat (2) tick();
        reset_i = 1'b1;
        sb.delete();
        tick();
        reset_i = 1'b0;
        checkOutput("sreset_valid_o", int'(valid_o), 0);
        checkOutput("sreset_q", int'(data_q_o), 0);
        checkOutput("sreset_ready_o", int'(ready_o), 1);

        $display("[TB] divide by zero");
`ifdef DIVIDER_DIV0_ERR_EN
        applyStimulus(8'd100, 4'd0, 8'd255, 4'd0, 1'b1);
        waitValid(20, cycles, readySeen);
        checkOutput("latency_div0", cycles, 0);
        checkOutput("div0_flag", int'(div_zero_o), 1);
`else
        applyStimulus(8'd100, 4'd0, 8'd255, 4'd4, 1'b0);
        waitValid(20, cycles, readySeen);
        checkOutput("latency_div0", cycles, 8);
`endif
        tick();

        $display("[TB] random operands");
        for (int i = 0; i < 200; i++) begin
            rn   = 8'($urandom_range(0, 255));
            rd   = 4'($urandom_range(0, 15));
            rres = model(rn, rd);
            applyStimulus(rn, rd, rres.q, rres.r, rres.dz);
            waitValid(20, cycles, readySeen);
            if (!valid_o) begin
                checkOutput("random_timeout", int'(valid_o), 1);
            end
            tick();
        end

        repeat (2) tick();
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
